rca_lsu_requester: RTL and testbench

RCA-side initiator for the load/store unit's RCA port. It queues memory requests from reconfigurable accelerator datapaths and arbitrates the LSU away from the CPU with a lock handshake. It issues address, data and fn3 requests when the LSU reports ready, and returns load results in order with the requester's tag. It sits between the RCA datapath and the LSU, driving the master end of the RCA–LSU interface.

---
 rtl/rca_lsu_requester_if.sv | 24 ++
 rtl/rca_lsu_requester.sv | 153 +++++++++++++++
 tb/tb_rca_lsu_requester.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/rca_lsu_requester_if.sv
// rtl/rca_lsu_requester_if.sv - RCA-to-LSU request/response bus
// Master is the RCA requester; slave is the load/store unit.
interface rca_lsu_requester_if;
  logic        rca_lsu_lock;
  logic        lsu_ready;
  logic        new_request;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  fn3;
  logic        load;
  logic        store;
  logic        load_complete;
  logic [31:0] load_data;

  modport master (
    output rca_lsu_lock, new_request, rs1, rs2, fn3, load, store,
    input  lsu_ready, load_complete, load_data
  );

  modport slave (
    input  rca_lsu_lock, new_request, rs1, rs2, fn3, load, store,
    output lsu_ready, load_complete, load_data
  );
endinterface

// File: rtl/rca_lsu_requester.sv
// rtl/rca_lsu_requester.sv - RCA-side LSU initiator: request FIFO, lock FSM, in-order load tags
// Optional RCA_LSU_ALIGN_CHECK_EN drops misaligned requests and pulses o_align_err.
module rca_lsu_requester #(
  parameter int DEPTH          = 4,
  parameter int MAX_LOADS      = 4,
  parameter int TAG_W          = 4,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [31:0]      i_req_addr,
  input  logic [31:0]      i_req_data,
  input  logic [2:0]       i_req_fn3,
  input  logic             i_req_load,
  input  logic             i_req_store,
  input  logic [TAG_W-1:0] i_req_tag,
  input  logic             i_rca_hold,
  output logic             o_rsp_valid,
  output logic [31:0]      o_rsp_data,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic             o_busy,
`ifdef RCA_LSU_ALIGN_CHECK_EN
  output logic             o_align_err,
  output logic [TAG_W-1:0] o_align_err_tag,
`endif
  rca_lsu_requester_if.master lsu
);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int OUT_W  = $clog2(MAX_LOADS + 1);
  localparam int TPTR_W = (MAX_LOADS > 1) ? $clog2(MAX_LOADS) : 1;
  localparam int REL_W  = $clog2(RELEASE_CYCLES + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACQUIRE = 2'd1;
  localparam logic [1:0] S_ACTIVE  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  typedef struct packed {
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [2:0]       fn3;
    logic             load;
    logic             store;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [TAG_W-1:0] r_tag_mem [MAX_LOADS];
  logic [TPTR_W-1:0] r_tag_wr, r_tag_rd;
  logic [OUT_W-1:0] r_outstanding;
  logic [1:0]       r_state;
  logic [REL_W-1:0] r_rel_cnt;

  req_t             w_in, w_head;
  logic             w_nonempty, w_locked, w_complete, w_misaligned;
  logic             w_push, w_pop, w_issue_load;
  logic [CNT_W-1:0] w_count_next;
  logic [OUT_W-1:0] w_out_next;

  assign w_in = '{addr: i_req_addr, data: i_req_data, fn3: i_req_fn3,
                  load: i_req_load, store: i_req_store, tag: i_req_tag};

`ifdef RCA_LSU_ALIGN_CHECK_EN
  assign w_misaligned = ((i_req_fn3[1:0] == 2'b01) && i_req_addr[0]) ||
                        ((i_req_fn3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
  assign o_align_err     = i_req_valid && o_req_ready && w_misaligned;
  assign o_align_err_tag = i_req_tag;
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_nonempty  = (r_count != '0);
  assign w_head      = w_nonempty ? r_mem[r_rd_ptr] : '0;
  assign o_req_ready = (r_count != CNT_W'(DEPTH));
  assign w_locked    = (r_state == S_ACQUIRE) || (r_state == S_ACTIVE);
  assign w_complete  = lsu.load_complete && (r_outstanding != '0);

  // A completion in this cycle frees a load slot, so a stalled load may issue alongside it.
  assign w_pop = w_locked && lsu.lsu_ready && w_nonempty &&
                 (w_head.store || (r_outstanding < OUT_W'(MAX_LOADS)) || w_complete);
  assign w_push       = i_req_valid && o_req_ready && !w_misaligned;
  assign w_issue_load = w_pop && w_head.load;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_out_next   = r_outstanding + OUT_W'(w_issue_load) - OUT_W'(w_complete);

  assign lsu.rca_lsu_lock = w_locked;
  assign lsu.new_request  = w_pop;
  assign lsu.rs1          = w_head.addr;
  assign lsu.rs2          = w_head.data;
  assign lsu.fn3          = w_head.fn3;
  assign lsu.load         = w_head.load;
  assign lsu.store        = w_head.store;

  assign o_rsp_valid = w_complete;
  assign o_rsp_data  = lsu.load_data;
  assign o_rsp_tag   = r_tag_mem[r_tag_rd];
  assign o_busy      = (r_state != S_IDLE) || w_nonempty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in;
    if (w_issue_load) r_tag_mem[r_tag_wr] <= w_head.tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_issue_load) r_tag_wr <= (r_tag_wr == TPTR_W'(MAX_LOADS - 1)) ? '0 : r_tag_wr + 1'b1;
      if (w_complete) r_tag_rd <= (r_tag_rd == TPTR_W'(MAX_LOADS - 1)) ? '0 : r_tag_rd + 1'b1;
      r_count       <= w_count_next;
      r_outstanding <= w_out_next;
    end
  end

  // Drain is judged on post-cycle occupancy so the lock drops right after the final issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rel_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE:    if (w_nonempty || i_rca_hold) r_state <= S_ACQUIRE;
        S_ACQUIRE: if (lsu.lsu_ready) r_state <= S_ACTIVE;
        S_ACTIVE: begin
          if ((w_count_next == '0) && (w_out_next == '0) && !i_rca_hold && !w_push) begin
            r_state   <= S_RELEASE;
            r_rel_cnt <= REL_W'(RELEASE_CYCLES - 1);
          end
        end
        default: begin
          if (r_rel_cnt == '0) r_state <= S_IDLE;
          else r_rel_cnt <= r_rel_cnt - 1'b1;
        end
      endcase
    end
  end

  a_no_spurious_complete: assert property (@(posedge clk) disable iff (rst)
    !(lsu.load_complete && (r_outstanding == '0)))
    else $warning("load_complete with no outstanding load was ignored");
endmodule

// File: tb/tb_rca_lsu_requester.sv
// tb/tb_rca_lsu_requester.sv - directed self-checking bench for rca_lsu_requester
// Optional RCA_LSU_ALIGN_CHECK_EN adds the misaligned-request vector.
module tb_rca_lsu_requester;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_load, i_req_store, i_rca_hold;
  logic        o_req_ready, o_rsp_valid, o_busy;
  logic [31:0] i_req_addr, i_req_data, o_rsp_data;
  logic [2:0]  i_req_fn3;
  logic [3:0]  i_req_tag, o_rsp_tag;
`ifdef RCA_LSU_ALIGN_CHECK_EN
  logic        o_align_err;
  logic [3:0]  o_align_err_tag;
`endif
  int n_checks = 0;
  int n_errors = 0;

  rca_lsu_requester_if u_lsu ();

  rca_lsu_requester #(.DEPTH(4), .MAX_LOADS(4), .TAG_W(4), .RELEASE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_fn3(i_req_fn3),
    .i_req_load(i_req_load), .i_req_store(i_req_store), .i_req_tag(i_req_tag),
    .i_rca_hold(i_rca_hold),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_tag(o_rsp_tag),
    .o_busy(o_busy),
`ifdef RCA_LSU_ALIGN_CHECK_EN
    .o_align_err(o_align_err), .o_align_err_tag(o_align_err_tag),
`endif
    .lsu(u_lsu.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic ld, input logic st, input logic [3:0] t);
    i_req_valid = 1'b1;
    i_req_addr  = a;
    i_req_data  = d;
    i_req_fn3   = f;
    i_req_load  = ld;
    i_req_store = st;
    i_req_tag   = t;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && o_busy; i++) cyc();
    #1;
    check(tag, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_addr = '0; i_req_data = '0; i_req_fn3 = '0;
    i_req_load = 1'b0; i_req_store = 1'b0; i_req_tag = '0; i_rca_hold = 1'b0;
    u_lsu.lsu_ready = 1'b0; u_lsu.load_complete = 1'b0; u_lsu.load_data = '0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    check("rst_lock", {31'd0, u_lsu.rca_lsu_lock}, 32'd0);
    check("rst_newreq", {31'd0, u_lsu.new_request}, 32'd0);
    check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("rst_rs1", u_lsu.rs1, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_req_ready", {31'd0, o_req_ready}, 32'd1);

    // Single LW, tag 3 at 0x100
    offer(32'h100, 32'h0, 3'b010, 1'b1, 1'b0, 4'd3);
    #1 check("lw_req_ready", {31'd0, o_req_ready}, 32'd1);
    cyc(); i_req_valid = 1'b0; #1;
    check("lw_lock_n1", {31'd0, u_lsu.rca_lsu_lock}, 32'd0);
    check("lw_busy_n1", {31'd0, o_busy}, 32'd1);
    check("lw_head_rs1", u_lsu.rs1, 32'h100);
    check("lw_head_load", {31'd0, u_lsu.load}, 32'd1);
    cyc(); #1;
    check("lw_lock_n2", {31'd0, u_lsu.rca_lsu_lock}, 32'd1);
    check("lw_noissue_n2", {31'd0, u_lsu.new_request}, 32'd0);
    cyc(); u_lsu.lsu_ready = 1'b1; #1;
    check("lw_issue_n3", {31'd0, u_lsu.new_request}, 32'd1);
    check("lw_issue_rs1", u_lsu.rs1, 32'h100);
    cyc(); u_lsu.lsu_ready = 1'b0; #1;
    check("lw_idle_issue", {31'd0, u_lsu.new_request}, 32'd0);
    check("lw_lock_wait", {31'd0, u_lsu.rca_lsu_lock}, 32'd1);
    check("lw_empty_rs1", u_lsu.rs1, 32'd0);
    cyc(); u_lsu.load_complete = 1'b1; u_lsu.load_data = 32'hDEADBEEF; #1;
    check("lw_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
    check("lw_rsp_data", o_rsp_data, 32'hDEADBEEF);
    check("lw_rsp_tag", {28'd0, o_rsp_tag}, 32'd3);
    cyc(); u_lsu.load_complete = 1'b0; #1;
    check("lw_rel1_lock", {31'd0, u_lsu.rca_lsu_lock}, 32'd0);
    check("lw_rel1_busy", {31'd0, o_busy}, 32'd1);
    check("lw_rel1_rsp", {31'd0, o_rsp_valid}, 32'd0);
    cyc(); #1;
    check("lw_rel2_busy", {31'd0, o_busy}, 32'd1);
    cyc(); #1;
    check("lw_idle_busy", {31'd0, o_busy}, 32'd0);

    // LB, tag 0 at 0x101
    offer(32'h101, 32'h0, 3'b000, 1'b1, 1'b0, 4'd0);
    cyc(); i_req_valid = 1'b0;
    cyc(); cyc(); u_lsu.lsu_ready = 1'b1; #1;
    check("lb_issue", {31'd0, u_lsu.new_request}, 32'd1);
    check("lb_rs1", u_lsu.rs1, 32'h101);
    check("lb_fn3", {29'd0, u_lsu.fn3}, 32'd0);
    cyc(); u_lsu.lsu_ready = 1'b0; u_lsu.load_complete = 1'b1; u_lsu.load_data = 32'hFFFFFF80; #1;
    check("lb_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
    check("lb_rsp_data", o_rsp_data, 32'hFFFFFF80);
    check("lb_rsp_tag", {28'd0, o_rsp_tag}, 32'd0);
    cyc(); u_lsu.load_complete = 1'b0;
    drain("lb_drain");

    // Four back-to-back SW
    for (int i = 0; i < 4; i++) begin
      offer(32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010, 1'b0, 1'b1, 4'(i));
      cyc();
    end
    i_req_valid = 1'b0; #1;
    check("sw_full_ready", {31'd0, o_req_ready}, 32'd0);
    check("sw_lock", {31'd0, u_lsu.rca_lsu_lock}, 32'd1);
    u_lsu.lsu_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("sw_issue", {31'd0, u_lsu.new_request}, 32'd1);
      check("sw_rs2", u_lsu.rs2, 32'hA0 + 32'(i));
      check("sw_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
      cyc();
    end
    #1;
    check("sw_lock_drop", {31'd0, u_lsu.rca_lsu_lock}, 32'd0);
    check("sw_no_issue", {31'd0, u_lsu.new_request}, 32'd0);
    u_lsu.lsu_ready = 1'b0;
    drain("sw_drain");

    // Six loads against MAX_LOADS=4
    for (int i = 0; i < 4; i++) begin
      offer(32'h300 + 32'(4 * i), 32'h0, 3'b010, 1'b1, 1'b0, 4'(8 + i));
      cyc();
    end
    i_req_valid = 1'b0; u_lsu.lsu_ready = 1'b1; #1;
    check("ml_issue0", {31'd0, u_lsu.new_request}, 32'd1);
    cyc(); offer(32'h310, 32'h0, 3'b010, 1'b1, 1'b0, 4'd12); #1;
    check("ml_issue1", {31'd0, u_lsu.new_request}, 32'd1);
    check("ml_rs1_1", u_lsu.rs1, 32'h304);
    cyc(); offer(32'h314, 32'h0, 3'b010, 1'b1, 1'b0, 4'd13); #1;
    check("ml_issue2", {31'd0, u_lsu.new_request}, 32'd1);
    check("ml_rs1_2", u_lsu.rs1, 32'h308);
    cyc(); i_req_valid = 1'b0; #1;
    check("ml_issue3", {31'd0, u_lsu.new_request}, 32'd1);
    check("ml_rs1_3", u_lsu.rs1, 32'h30C);
    cyc(); #1;
    check("ml_stall_a", {31'd0, u_lsu.new_request}, 32'd0);
    check("ml_stall_lock", {31'd0, u_lsu.rca_lsu_lock}, 32'd1);
    cyc(); #1;
    check("ml_stall_b", {31'd0, u_lsu.new_request}, 32'd0);
    cyc();
    for (int i = 0; i < 6; i++) begin
      u_lsu.load_complete = 1'b1; u_lsu.load_data = 32'h1000 + 32'(i); #1;
      check("ml_rsp_tag", {28'd0, o_rsp_tag}, 32'(8 + i));
      check("ml_rsp_data", o_rsp_data, 32'h1000 + 32'(i));
      check("ml_resume", {31'd0, u_lsu.new_request}, (i < 2) ? 32'd1 : 32'd0);
      check("ml_resume_rs1", u_lsu.rs1, (i < 2) ? 32'h310 + 32'(4 * i) : 32'd0);
      cyc();
    end
    u_lsu.load_complete = 1'b0; u_lsu.lsu_ready = 1'b0; #1;
    check("ml_lock_drop", {31'd0, u_lsu.rca_lsu_lock}, 32'd0);
    drain("ml_drain");

    // rca_hold with empty FIFO
    i_rca_hold = 1'b1;
    cyc(); #1;
    check("hold_lock", {31'd0, u_lsu.rca_lsu_lock}, 32'd1);
    u_lsu.lsu_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    #1;
    check("hold_kept", {31'd0, u_lsu.rca_lsu_lock}, 32'd1);
    check("hold_no_issue", {31'd0, u_lsu.new_request}, 32'd0);
    i_rca_hold = 1'b0; #1;
    check("hold_last", {31'd0, u_lsu.rca_lsu_lock}, 32'd1);
    cyc(); #1;
    check("hold_release", {31'd0, u_lsu.rca_lsu_lock}, 32'd0);
    u_lsu.lsu_ready = 1'b0;
    drain("hold_drain");

    // Reset with two loads in flight
    offer(32'h400, 32'h0, 3'b010, 1'b1, 1'b0, 4'd1);
    cyc(); offer(32'h404, 32'h0, 3'b010, 1'b1, 1'b0, 4'd2);
    cyc(); i_req_valid = 1'b0;
    cyc(); u_lsu.lsu_ready = 1'b1; #1;
    check("rs_issue_a", {31'd0, u_lsu.new_request}, 32'd1);
    cyc(); #1;
    check("rs_issue_b", u_lsu.rs1, 32'h404);
    cyc(); u_lsu.lsu_ready = 1'b0; #1;
    check("rs_pre_lock", {31'd0, u_lsu.rca_lsu_lock}, 32'd1);
    rst = 1'b1;
    cyc(); #1;
    check("rs_lock", {31'd0, u_lsu.rca_lsu_lock}, 32'd0);
    check("rs_busy", {31'd0, o_busy}, 32'd0);
    check("rs_req_ready", {31'd0, o_req_ready}, 32'd1);
    rst = 1'b0;
    cyc(); u_lsu.load_complete = 1'b1; u_lsu.load_data = 32'h5555AAAA; #1;
    check("rs_late_rsp", {31'd0, o_rsp_valid}, 32'd0);
    cyc(); u_lsu.load_complete = 1'b0; #1;
    check("rs_after_busy", {31'd0, o_busy}, 32'd0);

`ifdef RCA_LSU_ALIGN_CHECK_EN
    offer(32'h102, 32'h0, 3'b010, 1'b1, 1'b0, 4'd5); #1;
    check("al_err", {31'd0, o_align_err}, 32'd1);
    check("al_tag", {28'd0, o_align_err_tag}, 32'd5);
    check("al_ready", {31'd0, o_req_ready}, 32'd1);
    cyc(); i_req_valid = 1'b0; #1;
    check("al_not_queued", {31'd0, o_busy}, 32'd0);
    cyc(); cyc(); #1;
    check("al_no_issue", {31'd0, u_lsu.new_request}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
